// File: rtl/mips_imem_loader_pkg.sv
// Shared types and constants for the MIPS instruction-memory boot loader.
// IM_Addr_Width is also used by the instruction ROM so both sides agree on depth.
package mips_imem_loader_pkg;

  localparam int unsigned IM_Addr_Width    = 10;
  localparam int unsigned Loader_Max_Words = 2 ** IM_Addr_Width;

  typedef enum logic [2:0] {
    StHdrHi,
    StHdrLo,
    StWord,
    StCsum,
    StDone,
    StError
  } loader_state_t;

endpackage

// File: rtl/mips_imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// master drives the byte stream and observes memory writes; slave is the loader.
interface mips_imem_loader_if #(
  parameter int unsigned Data_Width = 32,
  parameter int unsigned Addr_Width = mips_imem_loader_pkg::IM_Addr_Width
);

  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  im_we;
  logic [Addr_Width-1:0] im_waddr;
  logic [Data_Width-1:0] im_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, im_we, im_waddr, im_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, im_we, im_waddr, im_wdata
  );

endinterface

// File: rtl/mips_imem_loader_word_assembler.sv
// Big-endian 8-to-32 shift register; word_valid pulses the cycle after the 4th byte,
// while word still holds the completed word.
module mips_imem_loader_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  input  logic        clear,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        word_valid
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;
  logic        valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= byte_en && (cnt_q == 2'd3) && !clear;
      if (clear) begin
        cnt_q <= '0;
      end else if (byte_en) begin
        word_q <= {word_q[23:0], byte_in};
        cnt_q  <= cnt_q + 2'd1;
      end
    end
  end

  assign word       = word_q;
  assign byte_cnt   = cnt_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/mips_imem_loader.sv
// Boot loader: parses a framed byte stream into instruction-memory writes and keeps
// the MIPS core in reset until a frame with a matching XOR checksum has been loaded.
module mips_imem_loader
  import mips_imem_loader_pkg::*;
#(
  parameter int unsigned Data_Width = 32,
  parameter int unsigned Addr_Width = IM_Addr_Width,
  parameter int unsigned Max_Words  = 2 ** Addr_Width
) (
  input  logic                clk,
  input  logic                rst,
  mips_imem_loader_if.slave   bus,
  input  logic                reload,
  output logic                core_rst,
  output logic                load_done,
  output logic                load_err,
  output logic [Addr_Width:0] words_loaded
);

  loader_state_t         state_q, state_d;
  logic [7:0]            count_hi_q;
  logic [15:0]           words_left_q;
  logic [7:0]            acc_q;
  logic [Addr_Width:0]   words_loaded_q;
  logic                  core_rst_q, load_done_q, load_err_q;

  logic                  accept, restart, last_byte, too_big;
  logic [15:0]           count_full;
  logic [Data_Width-1:0] asm_word;
  logic [1:0]            asm_cnt;
  logic                  asm_valid;

  assign accept     = bus.rx_valid && bus.rx_ready;
  assign restart    = reload && ((state_q == StDone) || (state_q == StError));
  assign count_full = {count_hi_q, bus.rx_data};
  assign too_big    = {1'b0, count_full} > 17'(Max_Words);
  assign last_byte  = accept && (state_q == StWord) && (asm_cnt == 2'd3);

  mips_imem_loader_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_en    (accept && (state_q == StWord)),
    .byte_in    (bus.rx_data),
    .clear      (restart),
    .word       (asm_word),
    .byte_cnt   (asm_cnt),
    .word_valid (asm_valid)
  );

  always_comb begin
    state_d      = state_q;
    bus.rx_ready = 1'b1;
    unique case (state_q)
      StHdrHi: if (accept) state_d = StHdrLo;
      StHdrLo: begin
        if (accept) begin
          if (too_big)                 state_d = StError;
          else if (count_full == 16'd0) state_d = StCsum;
          else                         state_d = StWord;
        end
      end
      StWord:  if (last_byte && (words_left_q == 16'd1)) state_d = StCsum;
      StCsum:  if (accept) state_d = (bus.rx_data == acc_q) ? StDone : StError;
      StDone, StError: begin
        bus.rx_ready = 1'b0;
        if (reload) state_d = StHdrHi;
      end
      default: state_d = StHdrHi;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StHdrHi;
      count_hi_q     <= '0;
      words_left_q   <= '0;
      acc_q          <= '0;
      words_loaded_q <= '0;
      core_rst_q     <= 1'b1;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_rst_q  <= (state_d != StDone);
      load_done_q <= (state_d == StDone);
      load_err_q  <= (state_d == StError);
      // The checksum byte itself is not folded into the running XOR.
      if (accept && (state_q != StCsum)) acc_q <= acc_q ^ bus.rx_data;
      if (accept && (state_q == StHdrHi)) count_hi_q <= bus.rx_data;
      if (accept && (state_q == StHdrLo)) words_left_q <= count_full;
      if (last_byte) words_left_q <= words_left_q - 16'd1;
      if (asm_valid) words_loaded_q <= words_loaded_q + {{Addr_Width{1'b0}}, 1'b1};
      if (restart) begin
        acc_q          <= '0;
        words_loaded_q <= '0;
      end
    end
  end

  assign bus.im_we    = asm_valid;
  assign bus.im_waddr = words_loaded_q[Addr_Width-1:0];
  assign bus.im_wdata = asm_word;
  assign core_rst     = core_rst_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Randomized and directed frames for the boot loader, scored against a frame-level
// reference model and a shadow of instruction memory built from observed writes.
module tb_mips_imem_loader;
  import mips_imem_loader_pkg::*;

  localparam int unsigned AW = IM_Addr_Width;
  localparam int unsigned MW = Loader_Max_Words;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reload = 1'b0;
  logic          core_rst, load_done, load_err;
  logic [AW:0]   words_loaded;

  mips_imem_loader_if #(.Data_Width(32), .Addr_Width(AW)) bus ();

  mips_imem_loader #(.Data_Width(32), .Addr_Width(AW), .Max_Words(MW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .reload       (reload),
    .core_rst     (core_rst),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Shadow instruction memory and write log, fed from the write bus.
  logic [31:0]   mem [0:MW-1];
  logic [AW-1:0] obs_addr[$];
  logic [31:0]   obs_data[$];

  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      obs_addr.push_back(bus.im_waddr);
      obs_data.push_back(bus.im_wdata);
      mem[bus.im_waddr] = bus.im_wdata;
    end
  end

  logic [7:0]  frame[$];
  logic [31:0] exp_words[$];
  bit          exp_ok;
  int          exp_acc;

  // Reference: parse the frame as a whole and predict outcome, bytes taken and writes.
  task automatic model_frame();
    int         count;
    logic [7:0] x;
    exp_words.delete();
    count = int'({frame[0], frame[1]});
    if (count > int'(MW)) begin
      exp_ok  = 1'b0;
      exp_acc = 2;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * count; i++) x = x ^ frame[i];
    for (int w = 0; w < count; w++)
      exp_words.push_back({frame[2+4*w], frame[3+4*w], frame[4+4*w], frame[5+4*w]});
    exp_acc = 3 + 4 * count;
    exp_ok  = (frame[2+4*count] == x);
  endtask

  task automatic build_frame(input int count, input bit bad_csum);
    logic [7:0] x, b;
    frame.delete();
    frame.push_back(8'(count >> 8));
    frame.push_back(8'(count));
    x = 8'(count >> 8) ^ 8'(count);
    for (int i = 0; i < 4 * count; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
      x = x ^ b;
    end
    if (bad_csum) x = x ^ 8'($urandom_range(1, 255));
    frame.push_back(x);
  endtask

  // gap_mode: 0 back-to-back, 1 valid toggles every cycle, 2 random idle cycles.
  task automatic send_bytes(input int limit, input int gap_mode, output int accepted);
    int g;
    accepted = 0;
    for (int i = 0; i < frame.size() && i < limit; i++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      @(negedge clk);
      repeat (g) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
      end
      if (bus.rx_ready !== 1'b1) begin
        bus.rx_valid = 1'b0;
        break;
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = frame[i];
      @(posedge clk);
      accepted++;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int gap_mode);
    int acc;
    model_frame();
    obs_addr.delete();
    obs_data.delete();
    send_bytes(frame.size(), gap_mode, acc);
    // Half a cycle after the last accepted byte the registered status must already show.
    check_eq({tag, " core_rst_after_last"}, 32'(core_rst), 32'(!exp_ok));
    repeat (3) @(negedge clk);
    check_eq({tag, " bytes_taken"}, 32'(acc), 32'(exp_acc));
    check_eq({tag, " load_done"}, 32'(load_done), 32'(exp_ok));
    check_eq({tag, " load_err"}, 32'(load_err), 32'(!exp_ok));
    check_eq({tag, " core_rst"}, 32'(core_rst), 32'(!exp_ok));
    check_eq({tag, " rx_ready"}, 32'(bus.rx_ready), 32'(0));
    check_eq({tag, " words_loaded"}, 32'(words_loaded), 32'(exp_words.size()));
    check_eq({tag, " n_writes"}, 32'(obs_addr.size()), 32'(exp_words.size()));
    for (int i = 0; i < obs_addr.size() && i < exp_words.size(); i++) begin
      check_eq($sformatf("%s waddr%0d", tag, i), 32'(obs_addr[i]), 32'(i));
      check_eq($sformatf("%s wdata%0d", tag, i), obs_data[i], exp_words[i]);
    end
  endtask

  // A byte offered together with reload must be refused; a later frame would misparse.
  task automatic do_reload(input string tag);
    @(negedge clk);
    reload       = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hFF;
    @(negedge clk);
    reload       = 1'b0;
    bus.rx_valid = 1'b0;
    check_eq({tag, " reload rx_ready"}, 32'(bus.rx_ready), 32'(1));
    check_eq({tag, " reload core_rst"}, 32'(core_rst), 32'(1));
    check_eq({tag, " reload done/err"}, 32'({load_done, load_err}), 32'(0));
    check_eq({tag, " reload words"}, 32'(words_loaded), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " im_we"}, 32'(bus.im_we), 32'(0));
    check_eq({tag, " im_waddr"}, 32'(bus.im_waddr), 32'(0));
    check_eq({tag, " im_wdata"}, bus.im_wdata, 32'(0));
    check_eq({tag, " core_rst"}, 32'(core_rst), 32'(1));
    check_eq({tag, " load_done"}, 32'(load_done), 32'(0));
    check_eq({tag, " load_err"}, 32'(load_err), 32'(0));
    check_eq({tag, " words_loaded"}, 32'(words_loaded), 32'(0));
    check_eq({tag, " rx_ready"}, 32'(bus.rx_ready), 32'(1));
  endtask

  logic [31:0] saved_w[$];
  logic [31:0] old_w1;
  int          acc_part;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08, 8'h27};
    run_frame("good2", 0);
    check_eq("good2 mem0", mem[0], 32'h2008_0005);
    check_eq("good2 mem1", mem[1], 32'h0000_0008);
    do_reload("good2");

    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08, 8'h26};
    run_frame("badcsum", 0);
    do_reload("badcsum");

    frame = '{8'h04, 8'h01, 8'hAA, 8'hBB};
    run_frame("oversize", 0);
    do_reload("oversize");

    frame = '{8'h00, 8'h00, 8'h00};
    run_frame("empty", 0);
    do_reload("empty");

    build_frame(3, 1'b0);
    run_frame("toggle3", 1);
    saved_w = obs_data;
    do_reload("toggle3");
    run_frame("b2b3", 0);
    check_eq("b2b3 vs toggle count", 32'(obs_data.size()), 32'(saved_w.size()));
    for (int i = 0; i < obs_data.size() && i < saved_w.size(); i++)
      check_eq($sformatf("b2b3 vs toggle w%0d", i), obs_data[i], saved_w[i]);
    do_reload("b2b3");

    // Reset in the middle of a frame, right as the first word is being written.
    build_frame(2, 1'b0);
    send_bytes(6, 0, acc_part);
    check_eq("midrst bytes", 32'(acc_part), 32'(6));
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    build_frame(2, 1'b0);
    run_frame("after_rst", 2);
    old_w1 = exp_words[1];
    do_reload("after_rst");
    build_frame(1, 1'b0);
    run_frame("overwrite", 0);
    check_eq("overwrite mem0", mem[0], exp_words[0]);
    check_eq("overwrite mem1 kept", mem[1], old_w1);
    do_reload("overwrite");

    for (int n = 0; n < 12; n++) begin
      int         kind;
      logic [7:0] hi, lo;
      kind = int'($urandom_range(0, 7));
      if (kind == 0) begin
        hi = 8'($urandom_range(4, 255));
        lo = 8'($urandom);
        if (hi == 8'h04 && lo == 8'h00) lo = 8'h01;
        frame = '{hi, lo, 8'h5A};
      end else begin
        build_frame(int'($urandom_range(0, 6)), kind == 1);
      end
      run_frame($sformatf("rand%0d", n), int'($urandom_range(0, 2)));
      do_reload($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
